mem_arbiter: RTL

Single-port data-RAM arbiter sharing one synchronous RAM between the execute-stage load/store port (D) and the instruction-fetch port (I). It sits between the core (ex stage, fetch unit) and the RAM macro: it grants at most one access per cycle, routes the one-cycle-late read data back to the owner, generates stall via withheld grants, and flags illegal requests without touching the RAM.

---
 rtl/mem_arbiter_pkg.sv | 37 +++
 rtl/mem_arb_prio.sv | 46 ++++
 rtl/mem_arbiter.sv | 114 +++++++++++
 3 files changed

// File: rtl/mem_arbiter_pkg.sv
// Shared encodings for the data-RAM arbiter: response owner, legal byte-select
// codes and write-enable levels.
package mem_arbiter_pkg;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_D    = 2'd1,
        OWN_I    = 2'd2
    } owner_e;

    localparam logic [3:0] SelByte0  = 4'b0001;
    localparam logic [3:0] SelByte1  = 4'b0010;
    localparam logic [3:0] SelByte2  = 4'b0100;
    localparam logic [3:0] SelByte3  = 4'b1000;
    localparam logic [3:0] SelHalfLo = 4'b0011;
    localparam logic [3:0] SelHalfHi = 4'b1100;
    localparam logic [3:0] SelWord   = 4'b1111;
    localparam logic [3:0] MenSelNop = 4'b0000;

    localparam logic WriteEnable  = 1'b1;
    localparam logic WriteDisable = 1'b0;

    // A D-side select is legal when it is a single byte, an aligned half-word
    // or an aligned word.
    function automatic logic sel_legal(input logic [3:0] sel, input logic [1:0] addr_lo);
        logic ok;
        case (sel)
            SelByte0, SelByte1, SelByte2, SelByte3: ok = 1'b1;
            SelHalfLo: ok = (addr_lo == 2'b00);
            SelHalfHi: ok = (addr_lo == 2'b10);
            SelWord:   ok = (addr_lo == 2'b00);
            default:   ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/mem_arb_prio.sv
// Grant decision between the D and I ports with a starvation counter that
// forces a waiting fetch through after STARVE_MAX consecutive D grants.
module mem_arb_prio #(
    parameter int unsigned STARVE_MAX = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic d_req,
    input  logic i_req,
    output logic d_gnt,
    output logic i_gnt
);

    localparam int unsigned CntW = $clog2(STARVE_MAX + 1);
    localparam logic [CntW-1:0] CntMax = CntW'(STARVE_MAX);

    logic [CntW-1:0] starve_q, starve_d;
    logic            force_i;

    // Grant decision: D wins unless I has waited long enough; nothing granted in reset.
    always_comb begin
        force_i = i_req && (starve_q == CntMax);
        i_gnt   = !rst && i_req && (!d_req || force_i);
        d_gnt   = !rst && d_req && !force_i;
    end

    // Starve counter next state: counts D grants that pass over a waiting I.
    always_comb begin
        starve_d = starve_q;
        if (i_gnt || !i_req) begin
            starve_d = '0;
        end else if (d_gnt && (starve_q != CntMax)) begin
            starve_d = starve_q + CntW'(1);
        end
    end

    // Starve counter register.
    always_ff @(posedge clk) begin
        if (rst) begin
            starve_q <= '0;
        end else begin
            starve_q <= starve_d;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Single-port RAM arbiter between the execute-stage load/store port (D) and the
// fetch port (I). Grants one access per cycle, rejects illegal requests without
// touching the RAM and returns the response one cycle later to its owner.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int unsigned ADDR_W     = 32,
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned STARVE_MAX = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [3:0]        d_sel,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_gnt,
    output logic              d_rvalid,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_err,
    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    output logic              i_gnt,
    output logic              i_rvalid,
    output logic [DATA_W-1:0] i_rdata,
    output logic              i_err,
    output logic              ram_en,
    output logic              ram_we,
    output logic [3:0]        ram_sel,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_rdata
);

    owner_e owner_q, owner_d;
    logic   err_q, err_d;
    logic   rd_q, rd_d;   // response carries RAM read data
    logic   d_ok, i_ok;

    mem_arb_prio #(
        .STARVE_MAX(STARVE_MAX)
    ) u_prio (
        .clk  (clk),
        .rst  (rst),
        .d_req(d_req),
        .i_req(i_req),
        .d_gnt(d_gnt),
        .i_gnt(i_gnt)
    );

    // RAM strobe and payload for the granted access; illegal requests stay off the RAM.
    always_comb begin
        d_ok      = sel_legal(d_sel, d_addr[1:0]);
        i_ok      = (i_addr[1:0] == 2'b00);
        ram_en    = 1'b0;
        ram_we    = WriteDisable;
        ram_sel   = MenSelNop;
        ram_addr  = '0;
        ram_wdata = '0;
        if (d_gnt && d_ok) begin
            ram_en    = 1'b1;
            ram_we    = d_we ? WriteEnable : WriteDisable;
            ram_sel   = d_sel;
            ram_addr  = d_addr;
            ram_wdata = d_wdata;
        end else if (i_gnt && i_ok) begin
            ram_en   = 1'b1;
            ram_we   = WriteDisable;
            ram_sel  = SelWord;
            ram_addr = i_addr;
        end
    end

    // Response owner next state, captured from this cycle's grant.
    always_comb begin
        owner_d = OWN_NONE;
        err_d   = 1'b0;
        rd_d    = 1'b0;
        if (d_gnt) begin
            owner_d = OWN_D;
            err_d   = !d_ok;
            rd_d    = d_ok && !d_we;
        end else if (i_gnt) begin
            owner_d = OWN_I;
            err_d   = !i_ok;
            rd_d    = i_ok;
        end
    end

    // Response owner register.
    always_ff @(posedge clk) begin
        if (rst) begin
            owner_q <= OWN_NONE;
            err_q   <= 1'b0;
            rd_q    <= 1'b0;
        end else begin
            owner_q <= owner_d;
            err_q   <= err_d;
            rd_q    <= rd_d;
        end
    end

    // Response routing; masked while rst is high so an in-flight response is dropped.
    always_comb begin
        d_rvalid = !rst && (owner_q == OWN_D);
        i_rvalid = !rst && (owner_q == OWN_I);
        d_err    = d_rvalid && err_q;
        i_err    = i_rvalid && err_q;
        d_rdata  = (d_rvalid && rd_q) ? ram_rdata : '0;
        i_rdata  = (i_rvalid && rd_q) ? ram_rdata : '0;
    end

endmodule
